// File: rtl/lstm_seq_driver.sv
// -----------------------------------------------------------------------------
// lstm_seq_driver
//
// Sequence-level initiator for an LSTM cell with a start/done handshake.
// Input vectors arrive on a valid/ready stream, one per timestep. For each
// timestep the driver captures x, fires a single-cycle cell_start, and holds
// x/h_prev/c_prev stable until the cell answers with cell_done. The returned
// h/c become h_prev/c_prev for the next timestep. Each h is then offered on a
// valid/ready output stream. A per-step watchdog aborts the sequence if the
// cell never answers.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   seq_start, seq_len     start pulse and length, sampled only while idle
//   seq_busy               high whenever a sequence is in progress
//   seq_done               one-cycle pulse at sequence end (normal, empty, abort)
//   timeout_err            sticky watchdog flag, cleared by the next seq_start
//   in_valid/in_ready/in_x input vector stream (ready only while waiting for x)
//   out_valid/out_ready    hidden-state output stream
//   out_h, out_last        current hidden state, final-step marker
//   cell_start/cell_done   cell handshake (single-cycle pulses both ways)
//   cell_x/h_prev/c_prev   cell operands, stable from start until done
//   cell_h/cell_c          cell results, valid while cell_done is high
//
// Vectors are flattened: element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
// Data passes through bit-exact; no arithmetic is applied to it.
// -----------------------------------------------------------------------------
module lstm_seq_driver #(
  parameter int INPUT_SIZE     = 2,
  parameter int HIDDEN_SIZE    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int SEQ_LEN_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              seq_start,
  input  logic [SEQ_LEN_WIDTH-1:0]          seq_len,
  output logic                              seq_busy,
  output logic                              seq_done,
  output logic                              timeout_err,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  in_x,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] out_h,
  output logic                              out_last,
  output logic                              cell_start,
  input  logic                              cell_done,
  output logic [INPUT_SIZE*DATA_WIDTH-1:0]  cell_x,
  output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_h_prev,
  output logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_c_prev,
  input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_h,
  input  logic [HIDDEN_SIZE*DATA_WIDTH-1:0] cell_c
);

  localparam int XW = INPUT_SIZE * DATA_WIDTH;
  localparam int HW = HIDDEN_SIZE * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  // The timer is cleared in START and counts WAIT_DONE cycles. Expiring when
  // it holds TIMEOUT_CYCLES-2 puts the abort exactly TIMEOUT_CYCLES cycles
  // after the cycle in which cell_start was high.
  localparam logic [TW-1:0] TIMER_EXPIRE = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [SEQ_LEN_WIDTH-1:0] LEN_ONE = SEQ_LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_X,
    S_START,
    S_WAIT_DONE,
    S_EMIT
  } state_t;

  state_t                   state;
  logic [XW-1:0]            x_reg;
  logic [HW-1:0]            h_state;
  logic [HW-1:0]            c_state;
  logic [SEQ_LEN_WIDTH-1:0] step;
  logic [SEQ_LEN_WIDTH-1:0] len;
  logic [TW-1:0]            timer;

  // Operands and the output vector are straight register views, so they can
  // only move when the FSM explicitly loads x_reg / h_state / c_state.
  assign cell_x      = x_reg;
  assign cell_h_prev = h_state;
  assign cell_c_prev = c_state;
  assign out_h       = h_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      x_reg       <= '0;
      h_state     <= '0;
      c_state     <= '0;
      step        <= '0;
      len         <= '0;
      timer       <= '0;
      seq_busy    <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      cell_start  <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises them for one cycle.
      seq_done   <= 1'b0;
      cell_start <= 1'b0;

      case (state)
        S_IDLE: begin
          if (seq_start) begin
            timeout_err <= 1'b0;
            if (seq_len != '0) begin
              len      <= seq_len;
              step     <= '0;
              h_state  <= '0;
              c_state  <= '0;
              seq_busy <= 1'b1;
              in_ready <= 1'b1;
              state    <= S_WAIT_X;
            end else begin
              // Empty sequence: report completion without touching the cell.
              seq_done <= 1'b1;
            end
          end
        end

        S_WAIT_X: begin
          // in_ready is high for the whole of this state.
          if (in_valid) begin
            x_reg      <= in_x;
            in_ready   <= 1'b0;
            cell_start <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          timer <= '0;
          state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          // Done is tested first so a response on the expiry cycle still wins.
          if (cell_done) begin
            h_state   <= cell_h;
            c_state   <= cell_c;
            out_valid <= 1'b1;
            out_last  <= (step == (len - LEN_ONE));
            state     <= S_EMIT;
          end else if (timer == TIMER_EXPIRE) begin
            timeout_err <= 1'b1;
            seq_done    <= 1'b1;
            seq_busy    <= 1'b0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              seq_done <= 1'b1;
              seq_busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              step     <= step + LEN_ONE;
              in_ready <= 1'b1;
              state    <= S_WAIT_X;
            end
          end
        end

        default: begin
          seq_busy  <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
